// File: rtl/div_sched_if.sv
// Request/response bundle between EXE and the divide scheduler.
//
// Handshake semantics: a request transfers on a rising edge where
// req_valid && req_ready are both high (and req_op is non-zero); a response
// transfers on a rising edge where resp_valid && resp_ready are both high.
// resp_valid, once raised, stays high with resp_result stable until the
// response transfers or cancel flushes it. cancel overrides both handshakes.
interface div_sched_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_src1;
    logic [WIDTH-1:0] req_src2;
    logic             req_ready;
    logic             busy;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_result;
    logic             resp_ready;
    logic             cancel;
    logic [2:0]       dbg_state;

    modport master (
        output req_valid, req_op, req_src1, req_src2, resp_ready, cancel,
        input  req_ready, busy, resp_valid, resp_result, dbg_state
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, resp_ready, cancel,
        output req_ready, busy, resp_valid, resp_result, dbg_state
    );
endinterface

// File: rtl/div_sched.sv
// Multi-cycle divide scheduler: one div.w/mod.w/div.wu/mod.wu at a time,
// radix-2 restoring shift-subtract core, sign fix-up, result held until EXE
// consumes it. dbg_state mirrors the FSM state register.
module div_sched #(
    parameter int WIDTH     = 32,
    parameter bit FAST_ZERO = 1'b1
) (
    input logic        clk,
    input logic        reset,
    div_sched_if.slave bus
);
    localparam int               CW        = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] INT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;   // 1: quotient, 0: remainder
    logic             sgn_q, sgn_d;         // signed operation
    logic [WIDTH-1:0] src1_q, src1_d;
    logic [WIDTH-1:0] src2_q, src2_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;         // divisor magnitude
    logic [WIDTH-1:0] rem_q, rem_d;         // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;         // dividend shifting out, quotient shifting in
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [3:0]       op_sel;
    logic             accept;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign bus.req_ready   = (state_q == S_IDLE) & ~bus.cancel & ~reset;
    assign bus.busy        = (state_q == S_PREP) | (state_q == S_CALC) | (state_q == S_FIX);
    assign bus.resp_valid  = (state_q == S_DONE);
    assign bus.resp_result = result_q;
    assign bus.dbg_state   = state_q;

    assign accept = bus.req_valid & bus.req_ready & (bus.req_op != 4'b0000);

    // Priority-select one op from a possibly multi-hot req_op: div_w > mod_w > div_wu > mod_wu.
    always_comb begin
        op_sel = 4'b0000;
        if (bus.req_op[3])      op_sel = 4'b1000;
        else if (bus.req_op[2]) op_sel = 4'b0100;
        else if (bus.req_op[1]) op_sel = 4'b0010;
        else if (bus.req_op[0]) op_sel = 4'b0001;
    end

    // Datapath helpers: operand magnitudes, one restoring step, and the final sign/special fix-up.
    always_comb begin
        abs1   = (sgn_q && src1_q[WIDTH-1]) ? -src1_q : src1_q;
        abs2   = (sgn_q && src2_q[WIDTH-1]) ? -src2_q : src2_q;
        // The shifted remainder can need one extra bit when the divisor is large.
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        if (src2_q == '0) begin
            quo_fix = '1;
            rem_fix = src1_q;
        end else if (sgn_q && (src1_q == INT_MIN) && (src2_q == '1)) begin
            quo_fix = INT_MIN;
            rem_fix = '0;
        end else begin
            quo_fix = q_neg_q ? -quo_q : quo_q;
            rem_fix = r_neg_q ? -rem_q : rem_q;
        end
    end

    // Next-state and datapath next values; cancel overrides everything at the end.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sgn_d    = sgn_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_PREP;
                    is_div_d = op_sel[3] | op_sel[1];
                    sgn_d    = op_sel[3] | op_sel[2];
                    src1_d   = bus.req_src1;
                    src2_d   = bus.req_src2;
                end
            end
            S_PREP: begin
                quo_d   = abs1;
                dvs_d   = abs2;
                rem_d   = '0;
                cnt_d   = '0;
                q_neg_d = sgn_q & (src1_q[WIDTH-1] ^ src2_q[WIDTH-1]);
                r_neg_d = sgn_q & src1_q[WIDTH-1];
                if (FAST_ZERO && (src2_q == '0)) state_d = S_FIX;
                else                             state_d = S_CALC;
            end
            S_CALC: begin
                // No borrow (diff MSB clear) means the divisor fits: keep the difference.
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) state_d = S_FIX;
            end
            S_FIX: begin
                result_d = is_div_q ? quo_fix : rem_fix;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.cancel) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Iteration counter and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sgn_q    <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sgn_q    <= sgn_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: directed cases from the divide rules plus randomized
// ops scored against an arithmetic reference model.
module tb_div_sched;
    localparam logic [3:0] OP_DIV_W  = 4'b1000;
    localparam logic [3:0] OP_MOD_W  = 4'b0100;
    localparam logic [3:0] OP_DIV_WU = 4'b0010;
    localparam logic [3:0] OP_MOD_WU = 4'b0001;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_q[$];

    div_sched_if #(.WIDTH(32)) bus ();

    div_sched #(.WIDTH(32), .FAST_ZERO(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: what the divide should return, from plain arithmetic.
    function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        bit is_div;
        bit is_sgn;
        int sa;
        int sb;
        is_div = 1'b0;
        is_sgn = 1'b0;
        if (op[3])      begin is_div = 1'b1; is_sgn = 1'b1; end
        else if (op[2]) begin is_div = 1'b0; is_sgn = 1'b1; end
        else if (op[1]) begin is_div = 1'b1; is_sgn = 1'b0; end
        if (b == 32'd0) return is_div ? 32'hFFFF_FFFF : a;
        if (is_sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_div ? 32'h8000_0000 : 32'd0;
            sa = a;
            sb = b;
            return is_div ? 32'(sa / sb) : 32'(sa % sb);
        end
        return is_div ? a / b : a % b;
    endfunction

    // driver: issue one op from IDLE, scramble operands after accept,
    // then count edges until resp_valid (lat=-1 on timeout)
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 4'b0000;
        bus.req_src1  = $urandom;
        bus.req_src2  = $urandom;
        lat = -1;
        res = '0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) begin
                lat = n;
                res = bus.resp_result;
                break;
            end
        end
    endtask

    // driver: consume the response
    task automatic consume();
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 4'b0000;
        bus.req_src1   = '0;
        bus.req_src2   = '0;
        bus.resp_ready = 1'b0;
        bus.cancel     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b0 || bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ready=%b busy=%b valid=%b, required 0 0 0",
                     bus.req_ready, bus.busy, bus.resp_valid);
        end
        n_checks++;
        if (bus.resp_result !== 32'd0 || bus.dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_values: result=%h state=%0d, required 0 and IDLE",
                     bus.resp_result, bus.dbg_state);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b, required 1", bus.req_ready);
        end
    endtask

    task automatic directed(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] want, input int want_lat);
        logic [31:0] res;
        int lat;
        run_op(op, a, b, res, lat);
        n_checks++;
        if (lat !== want_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d edges, required %0d", name, lat, want_lat);
        end
        n_checks++;
        if (res !== want) begin
            n_fail++;
            $display("FAIL %s_result: got %h, required %h", name, res, want);
        end
        consume();
        n_checks++;
        if (bus.dbg_state !== 3'd0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_release: state=%0d valid=%b ready=%b, required IDLE 0 1",
                     name, bus.dbg_state, bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_signed();
        directed("div_w_100_7", OP_DIV_W, 32'd100, 32'd7, 32'd14, 34);
        directed("mod_w_m100_7", OP_MOD_W, -32'sd100, 32'd7, 32'hFFFF_FFFE, 34);
        directed("div_w_m7_2", OP_DIV_W, -32'sd7, 32'd2, 32'hFFFF_FFFD, 34);
        directed("mod_w_7_m2", OP_MOD_W, 32'd7, -32'sd2, 32'd1, 34);
    endtask

    task automatic test_unsigned();
        directed("div_wu_max_2", OP_DIV_WU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 34);
        directed("mod_wu_max_16", OP_MOD_WU, 32'hFFFF_FFFF, 32'h10, 32'hF, 34);
        directed("div_wu_big_div", OP_DIV_WU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 34);
    endtask

    task automatic test_special();
        directed("div_w_by_zero", OP_DIV_W, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        directed("mod_w_by_zero", OP_MOD_W, 32'd5, 32'd0, 32'd5, 2);
        directed("mod_wu_by_zero", OP_MOD_WU, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 2);
        directed("div_w_overflow", OP_DIV_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        directed("mod_w_overflow", OP_MOD_W, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
        directed("prio_multi_hot", 4'b1111, -32'sd100, 32'd7, 32'hFFFF_FFF2, 34);
        directed("prio_mod_w", 4'b0111, -32'sd100, 32'd7, 32'hFFFF_FFFE, 34);
    endtask

    task automatic test_op_zero();
        bus.req_valid = 1'b1;
        bus.req_op    = 4'b0000;
        bus.req_src1  = 32'd9;
        bus.req_src2  = 32'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL op_zero_no_accept: busy=%b state=%0d, required 0 IDLE",
                     bus.busy, bus.dbg_state);
        end
    endtask

    task automatic test_cancel();
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIV_W;
        bus.req_src1  = 32'd1000;
        bus.req_src2  = 32'd10;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cancel_accept: busy=%b, required 1", bus.busy);
        end
        repeat (10) @(posedge clk);
        #1;
        bus.cancel = 1'b1;
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        n_checks++;
        if (bus.dbg_state !== 3'd0 || bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_to_idle: state=%0d busy=%b valid=%b, required IDLE 0 0",
                     bus.dbg_state, bus.busy, bus.resp_valid);
        end
        // a stale response from the cancelled op would appear before edge 34
        directed("after_cancel", OP_DIV_W, 32'd1000, 32'd10, 32'd100, 34);
    endtask

    task automatic test_hold();
        logic [31:0] res;
        int lat;
        run_op(OP_DIV_WU, 32'd123456, 32'd789, res, lat);
        n_checks++;
        if (res !== 32'd156 || lat !== 34) begin
            n_fail++;
            $display("FAIL hold_first: result=%h lat=%0d, required 0000009c 34", res, lat);
        end
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = OP_DIV_W;
            bus.req_src1  = $urandom;
            @(posedge clk); #1;
            n_checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_result !== 32'd156 || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: valid=%b result=%h ready=%b, required 1 0000009c 0",
                         i, bus.resp_valid, bus.resp_result, bus.req_ready);
            end
        end
        bus.req_valid = 1'b0;
        consume();
        n_checks++;
        if (bus.dbg_state !== 3'd0 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: state=%0d valid=%b, required IDLE 0",
                     bus.dbg_state, bus.resp_valid);
        end
    endtask

    task automatic test_async_reset();
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIV_W;
        bus.req_src1  = 32'd77777;
        bus.req_src2  = 32'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_result !== 32'd0
            || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b valid=%b result=%h ready=%b, required 0 0 0 0",
                     bus.busy, bus.resp_valid, bus.resp_result, bus.req_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIV_W;
        bus.cancel    = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.cancel    = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.dbg_state !== 3'd0) begin
            n_fail++;
            $display("FAIL valid_with_cancel: busy=%b state=%0d, required 0 IDLE",
                     bus.busy, bus.dbg_state);
        end
        directed("after_reset", OP_MOD_WU, 32'd77777, 32'd10, 32'd7, 34);
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] want;
        int lat;
        int want_lat;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(1, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 2000)) - 32'd1000;
                         b = 32'($urandom_range(0, 40)) - 32'd20; end
                3: b = 32'($urandom_range(1, 255));
                default: ;
            endcase
            exp_q.push_back(ref_model(op, a, b));
            want_lat = (b == 32'd0) ? 2 : 34;
            run_op(op, a, b, res, lat);
            want = exp_q.pop_front();
            n_checks++;
            if (res !== want || lat !== want_lat) begin
                n_fail++;
                $display("FAIL random%0d op=%b a=%h b=%h: result=%h lat=%0d, required %h %0d",
                         i, op, a, b, res, lat, want, want_lat);
            end
            consume();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_signed();
        test_unsigned();
        test_special();
        test_op_zero();
        test_cancel();
        test_hold();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Multi-cycle divide scheduler for the EXE stage. It accepts one div.w / mod.w / div.wu / mod.wu operation at a time from the decoded mul_div_op field.
- It sequences an internal radix-2 restoring shift-subtract core through a fixed iteration schedule, applies sign correction, and holds the result until EXE consumes it.
- EXE stalls (EXE_ready_go low) while busy is high, and flushes it via cancel on exception or branch squash.

Parameters:
- WIDTH, 32, operand and result width; the iteration count equals WIDTH.
- FAST_ZERO, 1, if 1 a zero divisor bypasses CALC and goes PREP->FIX directly.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  EXE holds a valid divide op.
- req_op  input  4  one-hot {div_w, mod_w, div_wu, mod_wu}, in the same order as mul_div_op[3:0].
- req_src1  input  WIDTH  dividend (rj).
- req_src2  input  WIDTH  divisor (rkd).
- req_ready  output  1  scheduler can accept a request this cycle.
- busy  output  1  an accepted op is in flight (PREP, CALC or FIX).
- resp_valid  output  1  result available.
- resp_result  output  WIDTH  quotient or remainder, as selected by the op.
- resp_ready  input  1  EXE consumes the result.
- cancel  input  1  flush the current or pending op.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, counter=0, all data registers=0.
  - req_ready=0 while reset is asserted; busy=0, resp_valid=0, resp_result=0.
- States: IDLE, PREP, CALC, FIX, DONE.
- req_ready = (state==IDLE) & ~cancel & ~reset.
- Accept = req_valid & req_ready & (req_op!=0).
  - req_op==0: nothing is accepted.
  - Multi-hot req_op: priority div_w > mod_w > div_wu > mod_wu.
- IDLE -> PREP on accept.
  - Latch the selected op, sign flag (signed ops), src1 and src2.
- PREP (1 cycle):
  - Form |src1| and |src2| for signed ops; raw values for unsigned ops.
  - Record q_neg = s1^s2 and r_neg = s1.
  - Clear the partial remainder; counter=0.
  - Next state: CALC. If FAST_ZERO=1 and divisor==0, go to FIX instead.
- CALC (exactly WIDTH cycles):
  - Each cycle: shift {rem, quo} left by 1 and trial-subtract the divisor from rem.
  - If no borrow, keep the difference and set quo[0]=1.
  - counter increments each cycle. Exit to FIX on the cycle where counter==WIDTH-1.
- FIX (1 cycle):
  - Negate quo if q_neg; negate rem if r_neg (the remainder takes the sign of the dividend).
  - Register resp_result according to the op. Next state: DONE.
- Special cases, forced in FIX regardless of the iteration result:
  - divisor==0: quotient = all ones; remainder = original src1.
  - Signed overflow (src1=0x80000000, src2=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- DONE:
  - resp_valid=1; resp_result is stable.
  - resp_ready=1 -> IDLE next edge. Otherwise stay in DONE with the result held unchanged.
- busy = state in {PREP, CALC, FIX}.
- Latency, with FAST_ZERO path not taken: resp_valid rises on the 34th edge after the accepting edge (1 PREP + 32 CALC + 1 FIX). The zero-divisor fast path takes 2 edges.
- Throughput: at least one IDLE cycle separates consecutive ops; there is no back-to-back accept in DONE.
- cancel, in any state:
  - Next edge: state=IDLE, resp_valid=0, counter=0.
  - No response is ever produced for a cancelled op.
  - cancel in DONE with resp_ready=1 at the same time: cancel wins, and the result counts as not consumed.
- Operands are sampled only at accept. Changes on req_src1/req_src2 afterwards have no effect.
- Asynchronous reset mid-operation: immediate return to the reset values above, with no partial output.

Test Plan:
- div_w 100 / 7 -> resp_valid 34 edges after accept, result 14; mod_w -100 % 7 -> -2 (0xFFFFFFFE).
- div_wu 0xFFFFFFFF / 2 -> 0x7FFFFFFF; mod_wu 0xFFFFFFFF % 0x10 -> 0xF; div_w -7 / 2 -> -3 (0xFFFFFFFD).
- div_w 5 / 0 -> 0xFFFFFFFF within 2 edges (FAST_ZERO=1); mod_w 5 / 0 -> 5; div_w 0x80000000 / 0xFFFFFFFF -> 0x80000000; mod_w of the same operands -> 0.
- Accept div_w 1000/10, assert cancel for 1 cycle 10 cycles later -> next edge IDLE, no resp_valid ever; a new req_valid is accepted in the following cycle and completes normally.
- Hold resp_ready=0 for 5 cycles in DONE while toggling req_src1 -> resp_valid stays 1, resp_result stays constant, req_ready stays 0; resp_ready=1 -> IDLE next edge.
- Assert reset asynchronously mid-CALC -> busy=0, resp_valid=0, resp_result=0 immediately; req_valid together with cancel -> no accept.
